// File: rtl/pong_pkg.sv
// Shared constants, FSM state type and helpers for the Pong renderer.
// Optional build macro: PONG_CENTER_NET_EN (dashed centre net colour).
package pong_pkg;

  localparam int H_VIS_START = 144;
  localparam int H_VIS_END   = 783;
  localparam int V_VIS_START = 35;
  localparam int V_VIS_END   = 514;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } game_state_e;

  localparam logic [3:0] COL_ON  = 4'hF;
  localparam logic [3:0] COL_OFF = 4'h0;
  localparam logic [3:0] COL_NET = 4'h8;

  // Keep a paddle top inside the screen so the whole paddle stays visible.
  function automatic logic [9:0] clamp_pad(input logic [9:0] y, input logic [9:0] y_max);
    return (y > y_max) ? y_max : y;
  endfunction

endpackage

// File: rtl/pong_ball_ctrl.sv
// Frame-rate game logic: serve/play/game-over FSM, ball motion, collisions, scores.
// Everything advances only on frame_tick so the raster never sees a torn frame.
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int BALL_SPEED     = 2,
  parameter int SERVE_FRAMES   = 60,
  parameter int WIN_SCORE      = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_tick,
  input  logic [9:0]  i_pad_l_y,
  input  logic [9:0]  i_pad_r_y,
  output logic [10:0] o_ball_x,
  output logic [10:0] o_ball_y,
  output game_state_e o_state,
  output logic [3:0]  o_score_l,
  output logic [3:0]  o_score_r
);

  localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

  localparam logic signed [10:0] SPD   = 11'(BALL_SPEED);
  localparam logic signed [10:0] ZERO  = 11'sd0;
  localparam logic signed [10:0] BX0   = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic signed [10:0] BY0   = 11'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - BALL_SIZE);
  localparam logic signed [10:0] L_HIT = 11'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic signed [10:0] R_HIT = 11'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [10:0]        PH    = 11'(PADDLE_H);
  localparam logic [10:0]        BS    = 11'(BALL_SIZE);
  localparam logic [3:0]         WIN   = 4'(WIN_SCORE);

  game_state_e       r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic signed [10:0] r_ball_x, r_ball_y, w_bx_nxt, w_by_nxt;
  logic              r_dx, r_dy, w_dx_nxt, w_dy_nxt;   // 1 = +1, 0 = -1
  logic [3:0]        r_score_l, r_score_r, w_sl_nxt, w_sr_nxt;

  logic signed [10:0] w_nx, w_ny;
  logic [10:0]        w_by_u;
  logic               w_ov_l, w_ov_r;
  logic [3:0]         w_sl_inc, w_sr_inc;

  assign w_nx     = r_ball_x + (r_dx ? SPD : -SPD);
  assign w_ny     = r_ball_y + (r_dy ? SPD : -SPD);
  assign w_by_u   = r_ball_y;
  // Vertical overlap is judged on the ball's current row span.
  assign w_ov_l   = (w_by_u < ({1'b0, i_pad_l_y} + PH)) && ((w_by_u + BS) > {1'b0, i_pad_l_y});
  assign w_ov_r   = (w_by_u < ({1'b0, i_pad_r_y} + PH)) && ((w_by_u + BS) > {1'b0, i_pad_r_y});
  assign w_sl_inc = r_score_l + 4'd1;
  assign w_sr_inc = r_score_r + 4'd1;

  // Next-state: serve countdown, ball step with wall/paddle bounce, miss scoring.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bx_nxt    = r_ball_x;
    w_by_nxt    = r_ball_y;
    w_dx_nxt    = r_dx;
    w_dy_nxt    = r_dy;
    w_sl_nxt    = r_score_l;
    w_sr_nxt    = r_score_r;
    if (i_frame_tick) begin
      case (r_state)
        SERVE: begin
          w_bx_nxt = BX0;
          w_by_nxt = BY0;
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = PLAY;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        PLAY: begin
          if (w_ny <= ZERO) begin
            w_by_nxt = ZERO;
            w_dy_nxt = 1'b1;
          end else if (w_ny >= Y_MAX) begin
            w_by_nxt = Y_MAX;
            w_dy_nxt = 1'b0;
          end else begin
            w_by_nxt = w_ny;
          end
          if (!r_dx && (w_nx <= L_HIT) && w_ov_l) begin
            w_bx_nxt = L_HIT;
            w_dx_nxt = 1'b1;
          end else if (r_dx && (w_nx >= R_HIT) && w_ov_r) begin
            w_bx_nxt = R_HIT;
            w_dx_nxt = 1'b0;
          end else if (!r_dx && (w_nx <= ZERO)) begin
            // Left player missed: re-serve towards the left again.
            w_sr_nxt    = w_sr_inc;
            w_dx_nxt    = 1'b0;
            w_bx_nxt    = BX0;
            w_by_nxt    = BY0;
            w_state_nxt = (w_sr_inc == WIN) ? GAME_OVER : SERVE;
          end else if (r_dx && (w_nx >= X_MAX)) begin
            w_sl_nxt    = w_sl_inc;
            w_dx_nxt    = 1'b1;
            w_bx_nxt    = BX0;
            w_by_nxt    = BY0;
            w_state_nxt = (w_sl_inc == WIN) ? GAME_OVER : SERVE;
          end else begin
            w_bx_nxt = w_nx;
          end
        end
        default: ;  // GAME_OVER holds until reset
      endcase
    end
  end

  // Game state register with synchronous reset to a fresh serve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= SERVE;
      r_cnt     <= '0;
      r_ball_x  <= BX0;
      r_ball_y  <= BY0;
      r_dx      <= 1'b1;
      r_dy      <= 1'b1;
      r_score_l <= 4'd0;
      r_score_r <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ball_x  <= w_bx_nxt;
      r_ball_y  <= w_by_nxt;
      r_dx      <= w_dx_nxt;
      r_dy      <= w_dy_nxt;
      r_score_l <= w_sl_nxt;
      r_score_r <= w_sr_nxt;
    end
  end

  assign o_ball_x  = r_ball_x;
  assign o_ball_y  = r_ball_y;
  assign o_state   = r_state;
  assign o_score_l = r_score_l;
  assign o_score_r = r_score_r;

endmodule

// File: rtl/pong_pixel_renderer.sv
// Pong colour stage behind the VGA timing counters: per-pixel ball/paddle
// compare into a pixel_en-gated colour register, frame logic in pong_ball_ctrl.
// Optional build macro: PONG_CENTER_NET_EN draws a dashed grey centre net.
module pong_pixel_renderer
  import pong_pkg::*;
#(
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int BALL_SPEED     = 2,
  parameter int SERVE_FRAMES   = 60,
  parameter int WIN_SCORE      = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pixel_en,
  input  logic [15:0] horizontal_count,
  input  logic [15:0] vertical_count,
  input  logic [9:0]  paddle_left_y,
  input  logic [9:0]  paddle_right_y,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        game_over
);

  localparam logic [9:0] PAD_MAX = 10'(SCREEN_H - PADDLE_H);

  logic [9:0]   w_pl, w_pr;
  logic [15:0]  w_x, w_y, w_bx, w_by, w_pl16, w_pr16;
  logic         w_vis, w_tick, w_ball_hit, w_padl_hit, w_padr_hit;
  logic [10:0]  w_ball_x, w_ball_y;
  game_state_e  w_state;
  logic [3:0]   w_col, r_col;

  assign w_pl   = clamp_pad(paddle_left_y, PAD_MAX);
  assign w_pr   = clamp_pad(paddle_right_y, PAD_MAX);
  assign w_tick = pixel_en && (horizontal_count == 16'd0) && (vertical_count == 16'(V_VIS_END + 1));

  pong_ball_ctrl #(
    .BALL_SIZE(BALL_SIZE), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H),
    .LEFT_PADDLE_X(LEFT_PADDLE_X), .RIGHT_PADDLE_X(RIGHT_PADDLE_X),
    .BALL_SPEED(BALL_SPEED), .SERVE_FRAMES(SERVE_FRAMES), .WIN_SCORE(WIN_SCORE)
  ) u_ctrl (
    .clk(clk), .rst_n(rst_n), .i_frame_tick(w_tick),
    .i_pad_l_y(w_pl), .i_pad_r_y(w_pr),
    .o_ball_x(w_ball_x), .o_ball_y(w_ball_y), .o_state(w_state),
    .o_score_l(score_left), .o_score_r(score_right)
  );

  assign w_vis  = (horizontal_count >= 16'(H_VIS_START)) && (horizontal_count <= 16'(H_VIS_END)) &&
                  (vertical_count >= 16'(V_VIS_START)) && (vertical_count <= 16'(V_VIS_END));
  assign w_x    = horizontal_count - 16'(H_VIS_START);
  assign w_y    = vertical_count - 16'(V_VIS_START);
  assign w_bx   = {5'd0, w_ball_x};
  assign w_by   = {5'd0, w_ball_y};
  assign w_pl16 = {6'd0, w_pl};
  assign w_pr16 = {6'd0, w_pr};

  assign w_ball_hit = (w_state != GAME_OVER) &&
                      (w_x >= w_bx) && (w_x < w_bx + 16'(BALL_SIZE)) &&
                      (w_y >= w_by) && (w_y < w_by + 16'(BALL_SIZE));
  assign w_padl_hit = (w_x >= 16'(LEFT_PADDLE_X)) && (w_x < 16'(LEFT_PADDLE_X + PADDLE_W)) &&
                      (w_y >= w_pl16) && (w_y < w_pl16 + 16'(PADDLE_H));
  assign w_padr_hit = (w_x >= 16'(RIGHT_PADDLE_X)) && (w_x < 16'(RIGHT_PADDLE_X + PADDLE_W)) &&
                      (w_y >= w_pr16) && (w_y < w_pr16 + 16'(PADDLE_H));

`ifdef PONG_CENTER_NET_EN
  logic w_net;
  assign w_net = (w_x >= 16'd318) && (w_x <= 16'd321) && !w_y[4];
`endif

  // Colour select: blanking, then ball, then paddles, then optional net.
  always_comb begin
    w_col = COL_OFF;
    if (w_vis) begin
      if (w_ball_hit || w_padl_hit || w_padr_hit) w_col = COL_ON;
`ifdef PONG_CENTER_NET_EN
      else if (w_net) w_col = COL_NET;
`endif
    end
  end

  // Colour register: one pixel_en of latency from counters to pins.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_col <= COL_OFF;
    else if (pixel_en) r_col <= w_col;
  end

  assign r         = r_col;
  assign g         = r_col;
  assign b         = r_col;
  assign game_over = (w_state == GAME_OVER);

endmodule

// File: tb/tb_pong_pixel_renderer.sv
// Self-checking bench for pong_pixel_renderer: reset, raster table, then a
// full game played by paddle-steering against a reference model of the rules.
module tb_pong_pixel_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pixel_en;
  logic [15:0] horizontal_count, vertical_count;
  logic [9:0]  paddle_left_y, paddle_right_y;
  logic [3:0]  r, g, b, score_left, score_right;
  logic        game_over;

  always #5 clk = ~clk;

  pong_pixel_renderer dut (
    .clk(clk), .rst_n(rst_n), .pixel_en(pixel_en),
    .horizontal_count(horizontal_count), .vertical_count(vertical_count),
    .paddle_left_y(paddle_left_y), .paddle_right_y(paddle_right_y),
    .r(r), .g(g), .b(b),
    .score_left(score_left), .score_right(score_right), .game_over(game_over)
  );

`ifdef PONG_CENTER_NET_EN
  localparam logic [3:0] NET_EXP = 4'h8;
`else
  localparam logic [3:0] NET_EXP = 4'h0;
`endif

  typedef struct {
    logic [15:0] h, v;
    logic [9:0]  pl, pr;
    logic        en;
    logic [3:0]  col;
  } vec_t;

  typedef struct {
    logic [3:0] col, sl, sr;
    logic       go;
    int         tag;
  } exp_t;

  exp_t q[$];
  vec_t tbl[22];
  int checks = 0;
  int errors = 0;

  // Reference game model (local coordinates, direction as +1/-1).
  int mx, my, mdx, mdy, ms_l, ms_r, mcnt, mst, hitl, hitr;

  task automatic model_reset();
    mx = 316; my = 236; mdx = 1; mdy = 1;
    ms_l = 0; ms_r = 0; mcnt = 0; mst = 0; hitl = 0; hitr = 0;
  endtask

  function automatic int clampp(input int p);
    return (p > 416) ? 416 : p;
  endfunction

  function automatic bit ov(input int by, input int p);
    return (by < p + 64) && (by + 8 > p);
  endfunction

  task automatic model_tick(input int pl, input int pr);
    int nx, ny;
    if (mst == 0) begin
      if (mcnt == 59) begin mcnt = 0; mst = 1; end
      else mcnt++;
    end else if (mst == 1) begin
      nx = mx + 2 * mdx;
      ny = my + 2 * mdy;
      if (ny <= 0) begin ny = 0; mdy = 1; end
      else if (ny >= 472) begin ny = 472; mdy = -1; end
      if (mdx < 0 && nx <= 24 && ov(my, pl)) begin nx = 24; mdx = 1; hitl++; end
      else if (mdx > 0 && nx >= 608 && ov(my, pr)) begin nx = 608; mdx = -1; hitr++; end
      else if (mdx < 0 && nx <= 0) begin
        ms_r++; mdx = -1; nx = 316; ny = 236; mst = (ms_r == 9) ? 2 : 0;
      end else if (mdx > 0 && nx >= 632) begin
        ms_l++; mdx = 1; nx = 316; ny = 236; mst = (ms_l == 9) ? 2 : 0;
      end
      mx = nx; my = ny;
    end
  endtask

  function automatic logic [3:0] mpix(input int x, input int y, input int pl, input int pr);
    int cl, cr;
    cl = clampp(pl); cr = clampp(pr);
    if (x < 0 || x > 639 || y < 0 || y > 479) return 4'h0;
    if (mst != 2 && x >= mx && x < mx + 8 && y >= my && y < my + 8) return 4'hF;
    if (x >= 16 && x < 24 && y >= cl && y < cl + 64) return 4'hF;
    if (x >= 616 && x < 624 && y >= cr && y < cr + 64) return 4'hF;
    if (x >= 318 && x <= 321 && ((y >> 4) & 1) == 0) return NET_EXP;
    return 4'h0;
  endfunction

  function automatic int trk(input int y);
    return (y < 28) ? 0 : y - 28;
  endfunction

  function automatic int away(input int y);
    return (y < 240) ? 400 : 0;
  endfunction

  task automatic collect();
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e = q.pop_front();
    if (r !== e.col || g !== e.col || b !== e.col || score_left !== e.sl ||
        score_right !== e.sr || game_over !== e.go) begin
      errors++;
      $display("FAIL chk_tag%0d got rgb=%h/%h/%h sl=%0d sr=%0d go=%b want rgb=%h sl=%0d sr=%0d go=%b",
               e.tag, r, g, b, score_left, score_right, game_over, e.col, e.sl, e.sr, e.go);
    end
  endtask

  task automatic drive(input logic [15:0] h, input logic [15:0] v, input logic [9:0] pl,
                       input logic [9:0] pr, input logic en, input logic [3:0] col, input int tag);
    exp_t e;
    @(negedge clk);
    horizontal_count = h; vertical_count = v;
    paddle_left_y = pl; paddle_right_y = pr; pixel_en = en;
    e.col = col; e.sl = 4'(ms_l); e.sr = 4'(ms_r); e.go = (mst == 2); e.tag = tag;
    q.push_back(e);
    @(negedge clk);
    pixel_en = 1'b0;
    collect();
  endtask

  task automatic probe(input int pl, input int pr, input int tag);
    int ox[5] = '{0, 7, -1, 8, 0};
    int oy[5] = '{0, 7, 0, 7, 8};
    int x, y;
    for (int k = 0; k < 5; k++) begin
      x = mx + ox[k]; y = my + oy[k];
      drive(16'(x + 144), 16'(y + 35), 10'(pl), 10'(pr), 1'b1, mpix(x, y, pl, pr), tag);
    end
  endtask

  task automatic tick(input int pl, input int pr, input bit do_probe, input int tag);
    model_tick(clampp(pl), clampp(pr));
    drive(16'd0, 16'd515, 10'(pl), 10'(pr), 1'b1, 4'h0, tag);
    if (do_probe) probe(pl, pr, tag + 50);
  endtask

  initial begin
    int t, a, c;
    tbl[0]  = '{16'd164, 16'd135, 10'd80,   10'd0, 1'b1, 4'hF};
    tbl[1]  = '{16'd100, 16'd135, 10'd80,   10'd0, 1'b1, 4'h0};
    tbl[2]  = '{16'd460, 16'd271, 10'd80,   10'd0, 1'b1, 4'hF};
    tbl[3]  = '{16'd467, 16'd278, 10'd80,   10'd0, 1'b1, 4'hF};
    tbl[4]  = '{16'd468, 16'd271, 10'd80,   10'd0, 1'b0, 4'hF};
    tbl[5]  = '{16'd468, 16'd271, 10'd80,   10'd0, 1'b1, 4'h0};
    tbl[6]  = '{16'd459, 16'd271, 10'd80,   10'd0, 1'b1, 4'h0};
    tbl[7]  = '{16'd460, 16'd270, 10'd80,   10'd0, 1'b1, 4'h0};
    tbl[8]  = '{16'd164, 16'd455, 10'd500,  10'd0, 1'b1, 4'hF};
    tbl[9]  = '{16'd164, 16'd450, 10'd500,  10'd0, 1'b1, 4'h0};
    tbl[10] = '{16'd164, 16'd514, 10'd1023, 10'd0, 1'b1, 4'hF};
    tbl[11] = '{16'd760, 16'd35,  10'd80,   10'd0, 1'b1, 4'hF};
    tbl[12] = '{16'd768, 16'd35,  10'd80,   10'd0, 1'b1, 4'h0};
    tbl[13] = '{16'd767, 16'd98,  10'd80,   10'd0, 1'b1, 4'hF};
    tbl[14] = '{16'd767, 16'd99,  10'd80,   10'd0, 1'b1, 4'h0};
    tbl[15] = '{16'd164, 16'd515, 10'd1023, 10'd0, 1'b1, 4'h0};
    tbl[16] = '{16'd143, 16'd135, 10'd80,   10'd0, 1'b1, 4'h0};
    tbl[17] = '{16'd160, 16'd135, 10'd80,   10'd0, 1'b1, 4'hF};
    tbl[18] = '{16'd159, 16'd135, 10'd80,   10'd0, 1'b1, 4'h0};
    tbl[19] = '{16'd168, 16'd135, 10'd80,   10'd0, 1'b1, 4'h0};
    tbl[20] = '{16'd783, 16'd514, 10'd80,   10'd0, 1'b1, 4'h0};
    tbl[21] = '{16'd784, 16'd271, 10'd80,   10'd0, 1'b1, 4'h0};

    // Reset held 3 cycles while a white pixel is presented.
    model_reset();
    rst_n = 1'b0; pixel_en = 1'b1;
    horizontal_count = 16'd164; vertical_count = 16'd135;
    paddle_left_y = 10'd80; paddle_right_y = 10'd0;
    repeat (3) @(negedge clk);
    q.push_back('{4'h0, 4'd0, 4'd0, 1'b0, 900});
    collect();
    rst_n = 1'b1; pixel_en = 1'b0;

    foreach (tbl[i])
      drive(tbl[i].h, tbl[i].v, tbl[i].pl, tbl[i].pr, tbl[i].en, tbl[i].col, i);

    // Rally: both paddles track until the left paddle has returned the ball.
    t = 0;
    while (hitl == 0 && t < 1000) begin
      a = trk(my); tick(a, a, 1'b1, 100); t++;
    end
    if (hitl == 0 || hitr == 0) begin
      errors++; $display("FAIL bound_rally hitl=%0d hitr=%0d", hitl, hitr);
    end

    // Left paddle steps away: left miss, right scores, back to serve.
    t = 0;
    while (ms_r == 0 && t < 1000) begin
      tick(away(my), trk(my), 1'b1, 200); t++;
    end
    if (ms_r == 0) begin
      errors++; $display("FAIL bound_left_miss");
    end
    drive(16'd460, 16'd271, 10'd0, 10'd0, 1'b1, 4'hF, 250);

    // Left tracks, right never defends: left wins.
    t = 0;
    while (mst != 2 && t < 5000) begin
      tick(trk(my), away(my), (t % 8) == 0, 300); t++;
    end
    if (mst != 2) begin
      errors++; $display("FAIL bound_game_over");
    end

    // Game over is sticky; ball hidden, scores frozen.
    for (int k = 0; k < 5; k++) begin
      c = (k * 97) % 417;
      tick(c, 416 - c, 1'b1, 400);
    end
    drive(16'd460, 16'd271, 10'd0, 10'd0, 1'b1, 4'h0, 450);
    drive(16'd462, 16'd35, 10'd100, 10'd100, 1'b1, NET_EXP, 451);

    // Reset in mid-frame on a white pixel: black next cycle, full restart.
    @(negedge clk);
    rst_n = 1'b0; pixel_en = 1'b1;
    horizontal_count = 16'd164; vertical_count = 16'd135; paddle_left_y = 10'd80;
    model_reset();
    q.push_back('{4'h0, 4'd0, 4'd0, 1'b0, 500});
    @(negedge clk);
    rst_n = 1'b1; pixel_en = 1'b0;
    collect();
    drive(16'd460, 16'd271, 10'd0, 10'd0, 1'b1, 4'hF, 501);
    tick(0, 0, 1'b1, 502);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
